// File: rtl/i2c_cmd_regbank.sv
// i2c_cmd_regbank: decodes I2C (command, data) words into shadowed channel registers.
// Define CHARGE_ARM_EN to require the timed 0xA6 arm before charging can turn on.
module i2c_cmd_regbank #(
  parameter int CH          = 6,
  parameter int DW          = 16,
  parameter int ARM_TIMEOUT = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rcv_succ,
  input  logic [7:0]       command,
  input  logic [DW-1:0]    data,
  input  logic             frame_sync,
  output logic [CH-1:0]    enable_trigger,
  output logic [CH-1:0]    enable_pwm,
  output logic             multi_pulse,
  output logic             enable_charging,
  output logic [DW-1:0]    frequency,
  output logic [CH*DW-1:0] pulse_width,
  output logic [CH*DW-1:0] pulse_delay,
  output logic [CH*DW-1:0] pwm_ctrl,
  output logic             cmd_ack,
  output logic             cmd_err,
  output logic             pending,
  output logic [7:0]       err_count
);

  localparam int CW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [DW-1:0] K_ON  = DW'(872);
  localparam logic [DW-1:0] K_OFF = DW'(278);
  localparam logic [DW-1:0] K_REP = DW'(1292);
  localparam logic [DW-1:0] K_SGL = DW'(2921);

  typedef enum logic [1:0] {
    IMMEDIATE,
    STAGED,
    COMMIT_WAIT
  } upd_t;

  typedef struct packed {
    logic [CH-1:0]         trig;
    logic [CH-1:0]         pwm;
    logic                  multi;
    logic [DW-1:0]         freq;
    logic [CH-1:0][DW-1:0] width;
    logic [CH-1:0][DW-1:0] delay;
    logic [CH-1:0][DW-1:0] pwmc;
  } regs_t;

  localparam regs_t RST_REGS = '{
    trig:  '0,
    pwm:   '0,
    multi: 1'b0,
    freq:  DW'(1),
    width: '0,
    delay: '0,
    pwmc:  '0
  };

  regs_t sh_q, sh_d, sh_w;
  regs_t act_q, act_d;
  upd_t  upd_q, upd_d;
  logic  pend_q, pend_d;

  logic          acc;
  logic          reg_wr;
  logic          mode_set;
  logic          mode_val;
  logic          commit_req;
  logic          abort_req;
  logic          chg_on;
  logic          chg_off;
  logic          arm_ok;
  logic          ch_ok;
  logic [3:0]    idx;
  logic [CW-1:0] ci;

`ifdef CHARGE_ARM_EN
  localparam int TW = $clog2(ARM_TIMEOUT + 1);
  localparam logic [DW-1:0] K_ARM = DW'(16'h5A5A);

  typedef enum logic {
    DISARMED,
    ARMED
  } arm_t;

  arm_t          arm_q, arm_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          arm_req;

  assign arm_ok = (arm_q == ARMED);
`else
  assign arm_ok = 1'b1;
`endif

  assign idx   = command[3:0];
  assign ch_ok = (idx != 4'd0) && (int'(idx) <= CH);
  assign ci    = CW'(idx - 4'd1);

  always_comb begin
    sh_w       = sh_q;
    acc        = 1'b0;
    reg_wr     = 1'b0;
    mode_set   = 1'b0;
    mode_val   = 1'b0;
    commit_req = 1'b0;
    abort_req  = 1'b0;
    chg_on     = 1'b0;
    chg_off    = 1'b0;
`ifdef CHARGE_ARM_EN
    arm_req    = 1'b0;
`endif
    if (rcv_succ) begin
      case (command)
        8'hA0: begin
          acc       = 1'b1;
          reg_wr    = 1'b1;
          sh_w.trig = data[DW/2 +: CH];
          sh_w.pwm  = data[CH-1:0];
        end
        8'hA1: begin
          if (data == K_ON && arm_ok) begin
            acc    = 1'b1;
            chg_on = 1'b1;
          end else if (data == K_OFF) begin
            acc     = 1'b1;
            chg_off = 1'b1;
          end
        end
        8'hA2: begin
          if (data == K_REP || data == K_SGL) begin
            acc        = 1'b1;
            reg_wr     = 1'b1;
            sh_w.multi = (data == K_REP);
          end
        end
        8'hA3: begin
          if (!pend_q && data <= DW'(1)) begin
            acc      = 1'b1;
            mode_set = 1'b1;
            mode_val = data[0];
          end
        end
        8'hA4: begin
          acc        = (upd_q != IMMEDIATE);
          commit_req = acc;
        end
        8'hA5: begin
          acc       = (upd_q != IMMEDIATE);
          abort_req = acc;
        end
`ifdef CHARGE_ARM_EN
        8'hA6: begin
          acc     = (data == K_ARM);
          arm_req = acc;
        end
`endif
        8'hB2: begin
          if (data != '0) begin
            acc       = 1'b1;
            reg_wr    = 1'b1;
            sh_w.freq = data;
          end
        end
        default: begin
          if (ch_ok) begin
            case (command[7:4])
              4'hC: begin
                acc            = 1'b1;
                reg_wr         = 1'b1;
                sh_w.width[ci] = data;
              end
              4'hD: begin
                acc            = 1'b1;
                reg_wr         = 1'b1;
                sh_w.delay[ci] = data;
              end
              4'hE: begin
                acc           = 1'b1;
                reg_wr        = 1'b1;
                sh_w.pwmc[ci] = data;
              end
              default: acc = 1'b0;
            endcase
          end
        end
      endcase
    end
  end

  // Commit copies the pre-write shadow; a same-cycle write lands after it.
  always_comb begin
    upd_d  = upd_q;
    pend_d = pend_q;
    sh_d   = sh_q;
    act_d  = act_q;
    if (upd_q == COMMIT_WAIT && frame_sync && !abort_req) begin
      act_d  = sh_q;
      pend_d = 1'b0;
      upd_d  = STAGED;
    end
    if (reg_wr) begin
      sh_d = sh_w;
      if (upd_q == IMMEDIATE) begin
        act_d = sh_w;
      end else begin
        pend_d = 1'b1;
      end
    end
    if (mode_set) begin
      upd_d = mode_val ? STAGED : IMMEDIATE;
    end
    if (commit_req) begin
      upd_d = COMMIT_WAIT;
    end
    if (abort_req) begin
      sh_d   = act_q;
      pend_d = 1'b0;
      upd_d  = STAGED;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_q   <= RST_REGS;
      act_q  <= RST_REGS;
      upd_q  <= IMMEDIATE;
      pend_q <= 1'b0;
    end else begin
      sh_q   <= sh_d;
      act_q  <= act_d;
      upd_q  <= upd_d;
      pend_q <= pend_d;
    end
  end

`ifdef CHARGE_ARM_EN
  always_comb begin
    arm_d = arm_q;
    tmr_d = tmr_q;
    if (arm_q == ARMED) begin
      tmr_d = tmr_q - TW'(1);
      if (tmr_q <= TW'(1) || rcv_succ) begin
        arm_d = DISARMED;
      end
    end
    if (arm_req) begin
      arm_d = ARMED;
      tmr_d = TW'(ARM_TIMEOUT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      arm_q <= DISARMED;
      tmr_q <= '0;
    end else begin
      arm_q <= arm_d;
      tmr_q <= tmr_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ack         <= 1'b0;
      cmd_err         <= 1'b0;
      err_count       <= 8'd0;
      enable_charging <= 1'b0;
    end else begin
      cmd_ack <= rcv_succ & acc;
      cmd_err <= rcv_succ & ~acc;
      if (rcv_succ && !acc && err_count != 8'hFF) begin
        err_count <= err_count + 8'd1;
      end
      if (chg_on) begin
        enable_charging <= 1'b1;
      end else if (chg_off) begin
        enable_charging <= 1'b0;
      end
    end
  end

  assign enable_trigger = act_q.trig;
  assign enable_pwm     = act_q.pwm;
  assign multi_pulse    = act_q.multi;
  assign frequency      = act_q.freq;
  assign pulse_width    = act_q.width;
  assign pulse_delay    = act_q.delay;
  assign pwm_ctrl       = act_q.pwmc;
  assign pending        = pend_q;

endmodule

// File: tb/tb_i2c_cmd_regbank.sv
// tb_i2c_cmd_regbank: directed checks of decode, staging, commit, charging and errors.
// Built with or without CHARGE_ARM_EN; the charging scenario follows the same macro.
module tb_i2c_cmd_regbank;

  localparam int CH = 6;
  localparam int DW = 16;
  localparam int AT = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             rcv_succ;
  logic [7:0]       command;
  logic [DW-1:0]    data;
  logic             frame_sync;
  logic [CH-1:0]    enable_trigger;
  logic [CH-1:0]    enable_pwm;
  logic             multi_pulse;
  logic             enable_charging;
  logic [DW-1:0]    frequency;
  logic [CH*DW-1:0] pulse_width;
  logic [CH*DW-1:0] pulse_delay;
  logic [CH*DW-1:0] pwm_ctrl;
  logic             cmd_ack;
  logic             cmd_err;
  logic             pending;
  logic [7:0]       err_count;

  int n_pass = 0;
  int n_tot  = 0;
  int exp_err = 0;

  i2c_cmd_regbank #(.CH(CH), .DW(DW), .ARM_TIMEOUT(AT)) dut (
    .clk(clk), .rst(rst), .rcv_succ(rcv_succ), .command(command),
    .data(data), .frame_sync(frame_sync),
    .enable_trigger(enable_trigger), .enable_pwm(enable_pwm),
    .multi_pulse(multi_pulse), .enable_charging(enable_charging),
    .frequency(frequency), .pulse_width(pulse_width),
    .pulse_delay(pulse_delay), .pwm_ctrl(pwm_ctrl),
    .cmd_ack(cmd_ack), .cmd_err(cmd_err), .pending(pending),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] wid(int k);
    return pulse_width[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] dly(int k);
    return pulse_delay[k*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] pwc(int k);
    return pwm_ctrl[k*DW +: DW];
  endfunction

  task automatic send(input logic [7:0] c, input logic [DW-1:0] d, input logic fs);
    @(negedge clk);
    command    = c;
    data       = d;
    rcv_succ   = 1'b1;
    frame_sync = fs;
    @(negedge clk);
    rcv_succ   = 1'b0;
    frame_sync = 1'b0;
  endtask

  task automatic fsync();
    @(negedge clk);
    frame_sync = 1'b1;
    @(negedge clk);
    frame_sync = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rcv_succ = 1'b0;
    frame_sync = 1'b0;
    command = 8'h00;
    data = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tot++;
    if ({enable_trigger, enable_pwm, multi_pulse, enable_charging} !== '0)
      $display("FAIL reset_enables got %h/%h/%b/%b want 0", enable_trigger,
               enable_pwm, multi_pulse, enable_charging);
    else n_pass++;
    n_tot++;
    if (frequency !== 16'd1)
      $display("FAIL reset_freq got %0d want 1", frequency);
    else n_pass++;
    n_tot++;
    if ({pulse_width, pulse_delay, pwm_ctrl} !== '0)
      $display("FAIL reset_chan got nonzero channel registers want 0");
    else n_pass++;
    n_tot++;
    if ({cmd_ack, cmd_err, pending, err_count} !== 11'd0)
      $display("FAIL reset_status got ack=%b err=%b pend=%b cnt=%0d want 0",
               cmd_ack, cmd_err, pending, err_count);
    else n_pass++;
  endtask

  task automatic test_immediate();
    send(8'hC3, 16'h1234, 1'b0);
    n_tot++;
    if (wid(2) !== 16'h1234)
      $display("FAIL imm_width2 got %h want 1234", wid(2));
    else n_pass++;
    n_tot++;
    if ({cmd_ack, cmd_err} !== 2'b10)
      $display("FAIL imm_ack got ack=%b err=%b want 1/0", cmd_ack, cmd_err);
    else n_pass++;
    n_tot++;
    if (wid(0) !== '0 || wid(3) !== '0 || frequency !== 16'd1)
      $display("FAIL imm_others got w0=%h w3=%h f=%0d want 0/0/1",
               wid(0), wid(3), frequency);
    else n_pass++;
    @(negedge clk);
    n_tot++;
    if (cmd_ack !== 1'b0)
      $display("FAIL imm_ack_pulse got %b want 0", cmd_ack);
    else n_pass++;
  endtask

  task automatic test_enable();
    send(8'hA0, 16'h2A15, 1'b0);
    n_tot++;
    if (enable_trigger !== 6'h2A || enable_pwm !== 6'h15)
      $display("FAIL enable got trig=%h pwm=%h want 2a/15",
               enable_trigger, enable_pwm);
    else n_pass++;
    send(8'hA2, 16'd1292, 1'b0);
    n_tot++;
    if (multi_pulse !== 1'b1 || cmd_ack !== 1'b1)
      $display("FAIL mode_repeat got mp=%b ack=%b want 1/1", multi_pulse, cmd_ack);
    else n_pass++;
  endtask

  task automatic test_staged();
    send(8'hA3, 16'd1, 1'b0);
    send(8'hB2, 16'd500, 1'b0);
    send(8'hD1, 16'd7, 1'b0);
    n_tot++;
    if (frequency !== 16'd1 || dly(0) !== '0 || pending !== 1'b1)
      $display("FAIL staged_hold got f=%0d d0=%0d pend=%b want 1/0/1",
               frequency, dly(0), pending);
    else n_pass++;
    send(8'hA4, 16'd0, 1'b0);
    n_tot++;
    if (cmd_ack !== 1'b1 || frequency !== 16'd1)
      $display("FAIL commit_req got ack=%b f=%0d want 1/1", cmd_ack, frequency);
    else n_pass++;
    fsync();
    n_tot++;
    if (frequency !== 16'd500 || dly(0) !== 16'd7 || pending !== 1'b0)
      $display("FAIL commit got f=%0d d0=%0d pend=%b want 500/7/0",
               frequency, dly(0), pending);
    else n_pass++;
  endtask

  task automatic test_abort();
    send(8'hE2, 16'd99, 1'b0);
    n_tot++;
    if (pending !== 1'b1 || pwc(1) !== '0)
      $display("FAIL abort_pre got pend=%b p1=%0d want 1/0", pending, pwc(1));
    else n_pass++;
    send(8'hA5, 16'd0, 1'b0);
    n_tot++;
    if (pending !== 1'b0 || pwc(1) !== '0 || cmd_ack !== 1'b1)
      $display("FAIL abort got pend=%b p1=%0d ack=%b want 0/0/1",
               pending, pwc(1), cmd_ack);
    else n_pass++;
    send(8'hA4, 16'd0, 1'b0);
    fsync();
    n_tot++;
    if (pwc(1) !== '0)
      $display("FAIL abort_commit got p1=%0d want 0", pwc(1));
    else n_pass++;
  endtask

  task automatic test_errors();
    send(8'hB2, 16'd0, 1'b0);
    exp_err++;
    n_tot++;
    if ({cmd_ack, cmd_err} !== 2'b01)
      $display("FAIL err_freq0 got ack=%b err=%b want 0/1", cmd_ack, cmd_err);
    else n_pass++;
    send(8'hC7, 16'd3, 1'b0);
    exp_err++;
    n_tot++;
    if (cmd_err !== 1'b1)
      $display("FAIL err_chan got err=%b want 1", cmd_err);
    else n_pass++;
    send(8'hA2, 16'd5, 1'b0);
    exp_err++;
    n_tot++;
    if (err_count !== 8'(exp_err))
      $display("FAIL err_count got %0d want %0d", err_count, exp_err);
    else n_pass++;
    n_tot++;
    if (frequency !== 16'd500 || multi_pulse !== 1'b1 || pending !== 1'b0)
      $display("FAIL err_nochange got f=%0d mp=%b pend=%b want 500/1/0",
               frequency, multi_pulse, pending);
    else n_pass++;
  endtask

  task automatic test_coincide();
    send(8'hA4, 16'd0, 1'b0);
    send(8'hC1, 16'd5, 1'b1);
    n_tot++;
    if (wid(0) !== '0 || pending !== 1'b1 || cmd_ack !== 1'b1)
      $display("FAIL coincide got w0=%0d pend=%b ack=%b want 0/1/1",
               wid(0), pending, cmd_ack);
    else n_pass++;
    send(8'hA3, 16'd0, 1'b0);
    exp_err++;
    n_tot++;
    if (cmd_err !== 1'b1 || err_count !== 8'(exp_err))
      $display("FAIL mode_while_pend got err=%b cnt=%0d want 1/%0d",
               cmd_err, err_count, exp_err);
    else n_pass++;
    send(8'hA4, 16'd0, 1'b0);
    fsync();
    n_tot++;
    if (wid(0) !== 16'd5 || pending !== 1'b0)
      $display("FAIL coincide_commit got w0=%0d pend=%b want 5/0", wid(0), pending);
    else n_pass++;
  endtask

  task automatic test_commit_same_cycle();
    send(8'hC2, 16'd9, 1'b0);
    send(8'hA4, 16'd0, 1'b1);
    n_tot++;
    if (wid(1) !== '0 || pending !== 1'b1)
      $display("FAIL a4_fs_same got w1=%0d pend=%b want 0/1", wid(1), pending);
    else n_pass++;
    fsync();
    n_tot++;
    if (wid(1) !== 16'd9 || pending !== 1'b0)
      $display("FAIL a4_fs_next got w1=%0d pend=%b want 9/0", wid(1), pending);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    send(8'hA3, 16'd0, 1'b0);
    @(negedge clk);
    rcv_succ = 1'b1;
    command  = 8'hC4;
    data     = 16'hAAAA;
    @(negedge clk);
    n_tot++;
    if (wid(3) !== 16'hAAAA || cmd_ack !== 1'b1)
      $display("FAIL b2b_first got w3=%h ack=%b want aaaa/1", wid(3), cmd_ack);
    else n_pass++;
    command = 8'hE6;
    data    = 16'hBBBB;
    @(negedge clk);
    rcv_succ = 1'b0;
    n_tot++;
    if (pwc(5) !== 16'hBBBB || cmd_ack !== 1'b1 || pending !== 1'b0)
      $display("FAIL b2b_second got p5=%h ack=%b pend=%b want bbbb/1/0",
               pwc(5), cmd_ack, pending);
    else n_pass++;
  endtask

  task automatic test_charge();
`ifdef CHARGE_ARM_EN
    send(8'hA1, 16'd872, 1'b0);
    exp_err++;
    n_tot++;
    if (cmd_err !== 1'b1 || enable_charging !== 1'b0)
      $display("FAIL chg_unarmed got err=%b en=%b want 1/0", cmd_err, enable_charging);
    else n_pass++;
    send(8'hA6, 16'h5A5A, 1'b0);
    send(8'hA1, 16'd872, 1'b0);
    n_tot++;
    if (cmd_ack !== 1'b1 || enable_charging !== 1'b1)
      $display("FAIL chg_armed got ack=%b en=%b want 1/1", cmd_ack, enable_charging);
    else n_pass++;
    send(8'hA1, 16'd278, 1'b0);
    send(8'hA6, 16'h5A5A, 1'b0);
    repeat (AT + 1) @(negedge clk);
    send(8'hA1, 16'd872, 1'b0);
    exp_err++;
    n_tot++;
    if (cmd_err !== 1'b1 || enable_charging !== 1'b0)
      $display("FAIL chg_timeout got err=%b en=%b want 1/0", cmd_err, enable_charging);
    else n_pass++;
    send(8'hA6, 16'h5A5A, 1'b0);
    send(8'hB2, 16'd300, 1'b0);
    send(8'hA1, 16'd872, 1'b0);
    exp_err++;
    n_tot++;
    if (cmd_err !== 1'b1 || frequency !== 16'd300)
      $display("FAIL chg_disarm got err=%b f=%0d want 1/300", cmd_err, frequency);
    else n_pass++;
`else
    send(8'hA6, 16'h5A5A, 1'b0);
    exp_err++;
    n_tot++;
    if (cmd_err !== 1'b1)
      $display("FAIL arm_unknown got err=%b want 1", cmd_err);
    else n_pass++;
    send(8'hA1, 16'd872, 1'b0);
    n_tot++;
    if (cmd_ack !== 1'b1 || enable_charging !== 1'b1)
      $display("FAIL chg_on got ack=%b en=%b want 1/1", cmd_ack, enable_charging);
    else n_pass++;
`endif
    send(8'hA1, 16'd278, 1'b0);
    n_tot++;
    if (cmd_ack !== 1'b1 || enable_charging !== 1'b0)
      $display("FAIL chg_off got ack=%b en=%b want 1/0", cmd_ack, enable_charging);
    else n_pass++;
    send(8'hA1, 16'd100, 1'b0);
    exp_err++;
    n_tot++;
    if (cmd_err !== 1'b1 || err_count !== 8'(exp_err))
      $display("FAIL chg_badkey got err=%b cnt=%0d want 1/%0d",
               cmd_err, err_count, exp_err);
    else n_pass++;
  endtask

  task automatic test_reset_midcommit();
    send(8'hA3, 16'd1, 1'b0);
    send(8'hC5, 16'd77, 1'b0);
    send(8'hA4, 16'd0, 1'b0);
    @(negedge clk);
    rst        = 1'b1;
    frame_sync = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    frame_sync = 1'b0;
    exp_err    = 0;
    n_tot++;
    if (wid(4) !== '0 || pending !== 1'b0 || frequency !== 16'd1 || err_count !== 8'd0)
      $display("FAIL rst_midcommit got w4=%0d pend=%b f=%0d cnt=%0d want 0/0/1/0",
               wid(4), pending, frequency, err_count);
    else n_pass++;
    send(8'hA4, 16'd0, 1'b0);
    exp_err++;
    n_tot++;
    if (cmd_err !== 1'b1)
      $display("FAIL commit_in_imm got err=%b want 1", cmd_err);
    else n_pass++;
  endtask

  task automatic test_saturate();
    @(negedge clk);
    command  = 8'h00;
    data     = '0;
    rcv_succ = 1'b1;
    repeat (260) @(negedge clk);
    rcv_succ = 1'b0;
    n_tot++;
    if (err_count !== 8'd255 || cmd_err !== 1'b1)
      $display("FAIL saturate got cnt=%0d err=%b want 255/1", err_count, cmd_err);
    else n_pass++;
    @(negedge clk);
    n_tot++;
    if (err_count !== 8'd255 || cmd_err !== 1'b0)
      $display("FAIL saturate_hold got cnt=%0d err=%b want 255/0", err_count, cmd_err);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_enable();
    test_staged();
    test_abort();
    test_errors();
    test_coincide();
    test_commit_same_cycle();
    test_back_to_back();
    test_charge();
    test_reset_midcommit();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
